// File: rtl/rgb_led_pwm_blink.sv
// Multi-channel LED driver: prescaled PWM brightness with off/on/blink/PWM modes.
// led is registered (1-clock latency from counter/active state); period_tick is a decode of registered counters.
// Configuration is double-buffered: load stages it, the next PWM period boundary applies it.
module rgb_led_pwm_blink #(
  parameter int NCH           = 3,
  parameter int DUTY_W        = 8,
  parameter int CLK_DIV       = 47,
  parameter int BLINK_PERIODS = 64,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [NCH-1:0]          en_mask,
  input  logic [NCH*DUTY_W-1:0]   duty,
  input  logic                    load,
  output logic [NCH-1:0]          led,
  output logic                    period_tick,
  output logic                    busy
);

  localparam int DIV_W = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV);
  localparam logic [BLK_W-1:0]  BLK_MAX = BLK_W'(BLINK_PERIODS - 1);
  localparam logic [DUTY_W-1:0] PWM_MAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  logic [DIV_W-1:0]        div_cnt;
  logic [DUTY_W-1:0]       pwm_cnt;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    phase;
  logic                    tick;
  logic                    boundary;

  mode_t                   stg_mode, act_mode;
  logic [NCH-1:0]          stg_mask, act_mask;
  logic [NCH*DUTY_W-1:0]   stg_duty, act_duty;
  logic [NCH-1:0]          lit;

  assign tick        = (div_cnt == DIV_MAX);
  assign boundary    = tick && (pwm_cnt == PWM_MAX);
  assign period_tick = boundary;

  // Prescaler: one tick every CLK_DIV+1 clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // PWM counter advances per tick and wraps naturally at 2^DUTY_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Blink phase flips every BLINK_PERIODS period boundaries; starts lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (boundary) begin
      if (blink_cnt == BLK_MAX) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Staging and active config. A load coinciding with a boundary is staged for
  // the following boundary, while this boundary still applies the older staged
  // values (non-blocking read of stg_* sees the pre-load contents).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_mode <= MODE_OFF;
      stg_mask <= '0;
      stg_duty <= '0;
      act_mode <= MODE_OFF;
      act_mask <= '0;
      act_duty <= '0;
      busy     <= 1'b0;
    end else begin
      if (load) begin
        stg_mode <= mode_t'(mode);
        stg_mask <= en_mask;
        stg_duty <= duty;
      end
      if (boundary && busy) begin
        act_mode <= stg_mode;
        act_mask <= stg_mask;
        act_duty <= stg_duty;
      end
      if (load) begin
        busy <= 1'b1;
      end else if (boundary) begin
        busy <= 1'b0;
      end
    end
  end

  // Per-channel lit decision from the active config; all-ones duty means fully on.
  always_comb begin
    lit = '0;
    for (int i = 0; i < NCH; i++) begin
      unique case (act_mode)
        MODE_OFF:   lit[i] = 1'b0;
        MODE_ON:    lit[i] = act_mask[i];
        MODE_BLINK: lit[i] = act_mask[i] & phase;
        MODE_PWM:   lit[i] = act_mask[i] &
                             ((act_duty[i*DUTY_W +: DUTY_W] == PWM_MAX) ||
                              (pwm_cnt < act_duty[i*DUTY_W +: DUTY_W]));
        default:    lit[i] = 1'b0;
      endcase
    end
  end

  // Registered LED drive with board polarity applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= {NCH{ACTIVE_LOW}};
    end else begin
      led <= lit ^ {NCH{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm_blink.sv
// Directed bench for rgb_led_pwm_blink: table of configs measured over one PWM
// period each, plus hand sequences for deferred apply, load collision, blink and reset.
module tb_rgb_led_pwm_blink;

  localparam int NCH = 3;
  localparam int DUTY_W = 4;
  localparam int CLK_DIV = 1;
  localparam int BLINK_PERIODS = 2;
  localparam int PER = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [2:0]  en_mask = 3'b000;
  logic [11:0] duty = 12'h000;
  logic        load = 1'b0;
  logic [2:0]  led;
  logic        period_tick;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0] m;
    logic [2:0] k;
    logic [3:0] dr, dg, db;
    int         lr, lg, lb;   // expected lit clocks per 32-clock period
  } vec_t;

  vec_t vecs[6];

  rgb_led_pwm_blink #(
    .NCH(NCH), .DUTY_W(DUTY_W), .CLK_DIV(CLK_DIV),
    .BLINK_PERIODS(BLINK_PERIODS), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .en_mask(en_mask), .duty(duty),
    .load(load), .led(led), .period_tick(period_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Waits (bounded) until period_tick is seen at a negedge sample.
  task automatic wait_tick(input string name);
    int n = 0;
    while (!period_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " tick"}, int'(period_tick), 1);
  endtask

  // Load a config and return at the negedge one clock after the applying boundary.
  task automatic apply_cfg(input logic [1:0] m, input logic [2:0] k,
                           input logic [11:0] d, input string name);
    mode = m; en_mask = k; duty = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check({name, " busy set"}, int'(busy), 1);
    wait_tick(name);
    @(negedge clk);
    check({name, " busy clear"}, int'(busy), 0);
  endtask

  // Sample one aligned period: lit count and length of the leading lit run per channel.
  task automatic measure(input vec_t v, input string name);
    int cnt[3];
    int run[3];
    int exp[3];
    for (int c = 0; c < 3; c++) begin cnt[c] = 0; run[c] = 0; end
    exp[0] = v.lr; exp[1] = v.lg; exp[2] = v.lb;
    for (int s = 0; s < PER; s++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (led[c] == 1'b0) begin
          cnt[c]++;
          if (run[c] == s) run[c]++;
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s ch%0d lit clocks", name, c), cnt[c], exp[c]);
      check($sformatf("%s ch%0d lit run", name, c), run[c], exp[c]);
    end
  endtask

  // Release reset at a negedge; the first boundary is cycle index 31 (the 32nd clock).
  task automatic release_and_count(input string name);
    int first = -1;
    rst = 1'b0;
    #1;
    check({name, " pt at release"}, int'(period_tick), 0);
    check({name, " led at release"}, int'(led), 7);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (period_tick && first < 0) first = i;
    end
    check({name, " first tick cycle"}, first, 31);
    check({name, " led still off"}, int'(led), 7);
  endtask

  initial begin
    int n, bad, bad2, pt_at, trans, last_t;
    logic prev;

    // {mode, mask, R, G, B, lit R, lit G, lit B}
    vecs[0] = '{2'b11, 3'b111, 4'd0,  4'd4,  4'd15, 0,  8,  32};
    vecs[1] = '{2'b11, 3'b111, 4'd1,  4'd8,  4'd14, 2,  16, 28};
    vecs[2] = '{2'b11, 3'b010, 4'd15, 4'd7,  4'd3,  0,  14, 0};
    vecs[3] = '{2'b01, 3'b101, 4'd0,  4'd0,  4'd0,  32, 0,  32};
    vecs[4] = '{2'b00, 3'b111, 4'd15, 4'd15, 4'd15, 0,  0,  0};
    vecs[5] = '{2'b11, 3'b101, 4'd15, 4'd15, 4'd0,  32, 0,  0};

    // Power-on reset state
    #1 rst = 1'b1;
    #2;
    check("reset led", int'(led), 7);
    check("reset busy", int'(busy), 0);
    check("reset period_tick", int'(period_tick), 0);
    @(negedge clk);
    release_and_count("por");

    // Table-driven configs
    for (int v = 0; v < 6; v++) begin
      apply_cfg(vecs[v].m, vecs[v].k, {vecs[v].db, vecs[v].dg, vecs[v].dr},
                $sformatf("vec%0d", v));
      measure(vecs[v], $sformatf("vec%0d", v));
    end

    // Deferred apply: steady on, then load off 5 clocks after a boundary
    apply_cfg(2'b01, 3'b111, 12'h000, "defer pre");
    @(negedge clk);
    wait_tick("defer sync");
    repeat (5) @(negedge clk);
    mode = 2'b00; en_mask = 3'b111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0; bad = 0; pt_at = -1;
    while (busy && n < 60) begin
      n++;
      if (led != 3'b000) bad++;
      if (period_tick) pt_at = n;
      @(negedge clk);
    end
    check("defer busy clocks", n, 27);
    check("defer led held", bad, 0);
    check("defer tick on last busy clock", pt_at, 27);
    @(negedge clk);
    check("defer new led", int'(led), 7);

    // Load collision: A pending, B in the boundary clock, C three clocks later
    mode = 2'b01; en_mask = 3'b001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_tick("coll first");
    en_mask = 3'b010; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("coll busy after B", int'(busy), 1);
    @(negedge clk);
    check("coll A applied", int'(led), 6);
    @(negedge clk);
    en_mask = 3'b100; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0; bad = 0;
    while (!period_tick && n < 40) begin
      if (led != 3'b110) bad++;
      n++;
      @(negedge clk);
    end
    check("coll second tick", int'(period_tick), 1);
    check("coll led held", bad, 0);
    @(negedge clk);
    check("coll busy clear", int'(busy), 0);
    @(negedge clk);
    check("coll C applied", int'(led), 3);

    // Blink on green only: toggles every 2 periods = 64 clocks
    apply_cfg(2'b10, 3'b010, 12'h000, "blink");
    prev = led[1]; trans = 0; last_t = -1; bad = 0; bad2 = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (led[0] != 1'b1 || led[2] != 1'b1) bad2++;
      if (led[1] != prev) begin
        if (last_t >= 0 && (t - last_t) != 64) bad++;
        last_t = t;
        trans++;
        prev = led[1];
      end
    end
    check("blink transitions", int'(trans >= 5), 1);
    check("blink bad gaps", bad, 0);
    check("blink other channels lit", bad2, 0);

    // Asynchronous reset mid-period while a config is pending
    apply_cfg(2'b11, 3'b111, 12'hFFF, "prereset");
    repeat (10) @(negedge clk);
    check("prereset all lit", int'(led), 0);
    duty = 12'h000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("prereset busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset led", int'(led), 7);
    check("async reset busy", int'(busy), 0);
    check("async reset period_tick", int'(period_tick), 0);
    @(negedge clk);
    release_and_count("midreset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
